// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes a MIPS instruction plus GPR operands into an ALU op/operand pair
// and queues it in a DEPTH-entry valid/ready FIFO feeding EX.
module alu_op_issue #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [31:0]      rs_data_i,
   input  logic [31:0]      rt_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [3:0]       alu_ctrl_o,
   output logic [31:0]      src1_o,
   output logic [31:0]      src2_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] issue_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [5:0]  op, fn;
   logic [4:0]  sh;
   logic [15:0] imm;
   logic [31:0] sext, zext, shamt;
   logic [3:0]  d_ctrl;
   logic [31:0] d_src1, d_src2;
   logic        d_ill;
   logic        unused_fields;

   assign op    = instr_i[31:26];
   assign fn    = instr_i[5:0];
   assign sh    = instr_i[10:6];
   assign imm   = instr_i[15:0];
   assign sext  = {{16{imm[15]}}, imm};
   assign zext  = {16'b0, imm};
   assign shamt = {21'b0, sh, 6'b0};
   assign unused_fields = ^instr_i[25:16];

   // Undecodable words still travel down the pipe, tagged illegal with ctrl 15.
   always_comb begin
      d_ctrl = 4'd15;
      d_src1 = '0;
      d_src2 = '0;
      d_ill  = 1'b1;
      case (op)
         6'h00: begin
            d_ill  = 1'b0;
            d_src1 = rs_data_i;
            d_src2 = rt_data_i;
            case (fn)
               6'h24: d_ctrl = 4'd0;
               6'h25: d_ctrl = 4'd1;
               6'h27: d_ctrl = 4'd3;
               6'h21: d_ctrl = 4'd4;
               6'h23: d_ctrl = 4'd5;
               6'h2A: d_ctrl = 4'd6;
               6'h2B: d_ctrl = 4'd11;
               6'h07: d_ctrl = 4'd9;
               6'h00: begin d_ctrl = 4'd12; d_src1 = shamt; end
               6'h03: begin d_ctrl = 4'd8;  d_src1 = shamt; end
               default: begin d_ill = 1'b1; d_src1 = '0; d_src2 = '0; end
            endcase
         end
         6'h09: begin d_ill = 1'b0; d_ctrl = 4'd4;  d_src1 = rs_data_i; d_src2 = sext; end
         6'h0B: begin d_ill = 1'b0; d_ctrl = 4'd11; d_src1 = rs_data_i; d_src2 = sext; end
         6'h0C: begin d_ill = 1'b0; d_ctrl = 4'd0;  d_src1 = rs_data_i; d_src2 = zext; end
         6'h0D: begin d_ill = 1'b0; d_ctrl = 4'd1;  d_src1 = rs_data_i; d_src2 = zext; end
         6'h0F: begin d_ill = 1'b0; d_ctrl = 4'd10; d_src2 = zext; end
         6'h04: begin d_ill = 1'b0; d_ctrl = 4'd5;  d_src1 = rs_data_i; d_src2 = rt_data_i; end
         default: ;
      endcase
   end

   logic [3:0]    ctrl_q [DEPTH];
   logic [31:0]   src1_q [DEPTH];
   logic [31:0]   src2_q [DEPTH];
   logic          ill_q  [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;

   assign in_ready_o  = count < CW'(DEPTH);
   assign out_valid_o = count != '0;
   assign push        = in_valid_i && in_ready_o && !flush_i;
   assign pop         = out_valid_o && out_ready_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         issue_cnt_o <= '0;
      end else if (flush_i) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         count <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr      <= rd_ptr + PW'(1);
            issue_cnt_o <= issue_cnt_o + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         ctrl_q[wr_ptr] <= d_ctrl;
         src1_q[wr_ptr] <= d_src1;
         src2_q[wr_ptr] <= d_src2;
         ill_q[wr_ptr]  <= d_ill;
      end
   end

   assign alu_ctrl_o = out_valid_o ? ctrl_q[rd_ptr] : '0;
   assign src1_o     = out_valid_o ? src1_q[rd_ptr] : '0;
   assign src2_o     = out_valid_o ? src2_q[rd_ptr] : '0;
   assign illegal_o  = out_valid_o ? ill_q[rd_ptr]  : 1'b0;
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed plus randomized checks of alu_op_issue against a queue-based
// reference model with a table-driven instruction decoder.
module tb_alu_op_issue;
   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush_i = 1'b0;
   logic             in_valid_i = 1'b0;
   logic             in_ready_o;
   logic [31:0]      instr_i = '0;
   logic [31:0]      rs_data_i = '0;
   logic [31:0]      rt_data_i = '0;
   logic             out_valid_o;
   logic             out_ready_i = 1'b0;
   logic [3:0]       alu_ctrl_o;
   logic [31:0]      src1_o;
   logic [31:0]      src2_o;
   logic             illegal_o;
   logic [CNT_W-1:0] issue_cnt_o;

   alu_op_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .alu_ctrl_o(alu_ctrl_o), .src1_o(src1_o), .src2_o(src2_o),
      .illegal_o(illegal_o), .issue_cnt_o(issue_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic        il;
   } ent_t;

   ent_t             q[$];
   logic [CNT_W-1:0] mcnt = '0;
   int               checks = 0;
   int               failures = 0;
   logic [5:0]       fns [11] = '{6'h24, 6'h25, 6'h27, 6'h21, 6'h23, 6'h2A, 6'h2B, 6'h00, 6'h03, 6'h07, 6'h01};
   logic [5:0]       ops [8]  = '{6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h3F, 6'h08};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
      ent_t        e;
      logic [31:0] se, ze;
      se = 32'($signed(i[15:0]));
      ze = 32'(i[15:0]);
      e = '{4'd15, 32'd0, 32'd0, 1'b1};
      if (i[31:26] == 6'h00) begin
         case (i[5:0])
            6'h24: e = '{4'd0, rs, rt, 1'b0};
            6'h25: e = '{4'd1, rs, rt, 1'b0};
            6'h27: e = '{4'd3, rs, rt, 1'b0};
            6'h21: e = '{4'd4, rs, rt, 1'b0};
            6'h23: e = '{4'd5, rs, rt, 1'b0};
            6'h2A: e = '{4'd6, rs, rt, 1'b0};
            6'h2B: e = '{4'd11, rs, rt, 1'b0};
            6'h07: e = '{4'd9, rs, rt, 1'b0};
            6'h00: e = '{4'd12, 32'(i[10:6]) * 64, rt, 1'b0};
            6'h03: e = '{4'd8, 32'(i[10:6]) * 64, rt, 1'b0};
            default: ;
         endcase
      end else begin
         case (i[31:26])
            6'h09: e = '{4'd4, rs, se, 1'b0};
            6'h0B: e = '{4'd11, rs, se, 1'b0};
            6'h0C: e = '{4'd0, rs, ze, 1'b0};
            6'h0D: e = '{4'd1, rs, ze, 1'b0};
            6'h0F: e = '{4'd10, 32'd0, ze, 1'b0};
            6'h04: e = '{4'd5, rs, rt, 1'b0};
            default: ;
         endcase
      end
      return e;
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
      return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd1, 5'd2, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r = {6'h00, r[25:6], fns[$urandom_range(0, 10)]};
      else r = {ops[$urandom_range(0, 7)], r[25:0]};
      return r;
   endfunction

   task automatic cmp_model();
      check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready_o), 32'(q.size() < DEPTH));
      check("issue_cnt", 32'(issue_cnt_o), 32'(mcnt));
      if (q.size() != 0) begin
         check("ctrl", 32'(alu_ctrl_o), 32'(q[0].c));
         check("src1", src1_o, q[0].a);
         check("src2", src2_o, q[0].b);
         check("illegal", 32'(illegal_o), 32'(q[0].il));
      end else begin
         check("ctrl_empty", 32'(alu_ctrl_o), 32'd0);
         check("src1_empty", src1_o, 32'd0);
         check("src2_empty", src2_o, 32'd0);
         check("illegal_empty", 32'(illegal_o), 32'd0);
      end
   endtask

   // One clock: check against the model, drive, advance, update the model, go idle.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic fl);
      logic do_push, do_pop;
      ent_t e;
      @(negedge clk_i);
      cmp_model();
      in_valid_i = v; instr_i = ins; rs_data_i = rs; rt_data_i = rt;
      out_ready_i = ordy; flush_i = fl;
      do_push = v && q.size() < DEPTH && !fl;
      do_pop  = q.size() != 0 && ordy && !fl;
      e = ref_dec(ins, rs, rt);
      @(posedge clk_i);
      if (fl) q.delete();
      else begin
         if (do_pop) begin void'(q.pop_front()); mcnt = mcnt + 1'b1; end
         if (do_push) q.push_back(e);
      end
      #1;
      in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      cmp_model();
      rst_n = 1'b1;

      // T1: ADDU passes through with one cycle latency
      step(1'b1, rtype(6'h21, 5'd0), 32'd5, 32'd7, 1'b1, 1'b0);
      @(negedge clk_i);
      check("t1_valid", 32'(out_valid_o), 32'd1);
      check("t1_ctrl", 32'(alu_ctrl_o), 32'd4);
      check("t1_src1", src1_o, 32'd5);
      check("t1_src2", src2_o, 32'd7);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk_i);
      check("t1_cnt", 32'(issue_cnt_o), 32'd1);
      check("t1_empty", 32'(out_valid_o), 32'd0);

      // T2: immediate extension
      step(1'b1, itype(6'h09, 16'hFFFE), 32'd3, 32'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t2_addiu", src2_o, 32'hFFFFFFFE);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, itype(6'h0B, 16'h8000), 32'd3, 32'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t2_sltiu", src2_o, 32'hFFFF8000);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, itype(6'h0D, 16'h8000), 32'd3, 32'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t2_ori", src2_o, 32'h00008000);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, itype(6'h0F, 16'h1234), 32'd3, 32'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t2_lui_ctrl", 32'(alu_ctrl_o), 32'd10);
      check("t2_lui_src2", src2_o, 32'h00001234);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // T3: shifts
      step(1'b1, rtype(6'h00, 5'd4), 32'hDEAD, 32'd1, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t3_sll_ctrl", 32'(alu_ctrl_o), 32'd12);
      check("t3_sll_src1", src1_o, 32'h00000100);
      check("t3_sll_src2", src2_o, 32'd1);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, rtype(6'h07, 5'd0), 32'h0000_0013, 32'h8000_0000, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t3_srav_ctrl", 32'(alu_ctrl_o), 32'd9);
      check("t3_srav_src1", src1_o, 32'h13);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // T4: backpressure, then drain in order
      step(1'b1, rtype(6'h24, 5'd0), 32'd1, 32'd2, 1'b0, 1'b0);
      step(1'b1, rtype(6'h25, 5'd0), 32'd3, 32'd4, 1'b0, 1'b0);
      step(1'b1, rtype(6'h27, 5'd0), 32'd5, 32'd6, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t4_full", 32'(in_ready_o), 32'd0);
      step(1'b1, rtype(6'h27, 5'd0), 32'd5, 32'd6, 1'b1, 1'b0);
      step(1'b1, rtype(6'h27, 5'd0), 32'd5, 32'd6, 1'b1, 1'b0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // T5: flush of a full queue drops the incoming op and counts nothing
      step(1'b1, rtype(6'h2A, 5'd0), 32'd9, 32'd8, 1'b0, 1'b0);
      step(1'b1, rtype(6'h2B, 5'd0), 32'd7, 32'd6, 1'b0, 1'b0);
      step(1'b1, rtype(6'h23, 5'd0), 32'd5, 32'd4, 1'b1, 1'b1);
      @(negedge clk_i);
      check("t5_valid", 32'(out_valid_o), 32'd0);
      check("t5_ready", 32'(in_ready_o), 32'd1);

      // T6: illegal op is queued and counted
      step(1'b1, 32'hFC00_0000, 32'd1, 32'd2, 1'b0, 1'b0);
      @(negedge clk_i);
      check("t6_illegal", 32'(illegal_o), 32'd1);
      check("t6_ctrl", 32'(alu_ctrl_o), 32'd15);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      repeat (500)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

      // Asynchronous reset mid-stream
      step(1'b1, rtype(6'h21, 5'd0), 32'd1, 32'd1, 1'b0, 1'b0);
      step(1'b1, rtype(6'h21, 5'd0), 32'd2, 32'd2, 1'b0, 1'b0);
      @(negedge clk_i);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      mcnt = '0;
      cmp_model();
      @(negedge clk_i);
      rst_n = 1'b1;
      step(1'b1, rtype(6'h25, 5'd0), 32'd4, 32'd5, 1'b1, 1'b0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk_i);
      cmp_model();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
